// File: rtl/mcu_window_router.sv
// Line-memory router for the convolution datapath: round-robin bank load, rotating 3-row
// convolver windows with write-back, and a valid/ready drain port. All outputs registered.
module mcu_window_router #(
  parameter int unsigned N           = 2,
  parameter int unsigned BITS_IMAGEN = 11,
  parameter int unsigned BITS_DATA   = BITS_IMAGEN
) (
  input  logic                         i_CLK,
  input  logic                         i_reset,
  input  logic [1:0]                   i_cmd,
  input  logic                         i_cmd_valid,
  input  logic                         i_valid,
  input  logic [BITS_DATA-1:0]         i_Data,
  input  logic [(N+2)*BITS_IMAGEN-1:0] i_MemData,
  input  logic [N*BITS_IMAGEN-1:0]     i_DataConv,
  input  logic                         i_advance,
  input  logic                         i_ready,
  output logic [(N+2)*BITS_IMAGEN-1:0] o_MemData,
  output logic [N+1:0]                 o_MemWe,
  output logic [3*N*BITS_IMAGEN-1:0]   o_DataConv,
  output logic                         o_conv_valid,
  output logic [BITS_DATA-1:0]         o_Data,
  output logic                         o_valid,
  output logic [1:0]                   o_state
);

  localparam int unsigned M    = N + 2;
  localparam int unsigned W    = BITS_IMAGEN;
  localparam int unsigned PtrW = $clog2(M);

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StLoad  = 2'b01,
    StRun   = 2'b10,
    StDrain = 2'b11
  } state_e;

  state_e                 state_q, state_d;
  logic [PtrW-1:0]        load_ptr_q, load_ptr_d;
  logic [PtrW-1:0]        rot_q, rot_d;
  logic [PtrW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [M*W-1:0]         mem_data_q, mem_data_d;
  logic [M-1:0]           mem_we_q, mem_we_d;
  logic [3*N*W-1:0]       conv_q, conv_d;
  logic                   conv_valid_q, conv_valid_d;
  logic [BITS_DATA-1:0]   data_q, data_d;
  logic                   valid_q, valid_d;

  // Bank index base+off with a single explicit wrap; off never exceeds M-1.
  function automatic int unsigned bank_idx(input logic [PtrW-1:0] base, input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= M) s = s - M;
    return s;
  endfunction

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(M - 1)) ? '0 : p + PtrW'(1);
  endfunction

  always_comb begin
    int unsigned b0, b1, b2, lp, rp;
    state_d      = state_q;
    load_ptr_d   = load_ptr_q;
    rot_d        = rot_q;
    rd_ptr_d     = rd_ptr_q;
    mem_data_d   = '0;
    mem_we_d     = '0;
    conv_d       = conv_q;
    conv_valid_d = 1'b0;
    data_d       = data_q;
    valid_d      = 1'b0;
    b0           = 0;
    b1           = 0;
    b2           = 0;
    lp           = 32'(load_ptr_q);
    rp           = 32'(rd_ptr_q);

    unique case (state_q)
      StIdle: ;
      StLoad: begin
        if (i_valid) begin
          mem_we_d[lp]           = 1'b1;
          mem_data_d[lp*W +: W]  = W'(i_Data);
          load_ptr_d             = ptr_inc(load_ptr_q);
        end
      end
      StRun: begin
        if (i_valid) begin
          for (int unsigned k = 0; k < N; k++) begin
            b0 = bank_idx(rot_q, k);
            b1 = bank_idx(rot_q, k + 1);
            b2 = bank_idx(rot_q, k + 2);
            conv_d[(3*k)*W   +: W] = i_MemData[b0*W +: W];
            conv_d[(3*k+1)*W +: W] = i_MemData[b1*W +: W];
            conv_d[(3*k+2)*W +: W] = i_MemData[b2*W +: W];
            mem_we_d[b0]           = 1'b1;
            mem_data_d[b0*W +: W]  = i_DataConv[k*W +: W];
          end
          conv_valid_d = 1'b1;
        end
        if (i_advance) rot_d = PtrW'(bank_idx(rot_q, N));
      end
      StDrain: begin
        valid_d = valid_q;
        if (!valid_q || i_ready) begin
          data_d   = i_MemData[rp*W +: BITS_DATA];
          valid_d  = 1'b1;
          rd_ptr_d = ptr_inc(rd_ptr_q);
        end
      end
      default: ;
    endcase

    // A command takes effect next cycle; any command drops o_valid since either
    // DRAIN is left or re-entered with a fresh pointer.
    if (i_cmd_valid) begin
      state_d = state_e'(i_cmd);
      valid_d = 1'b0;
      unique case (state_e'(i_cmd))
        StLoad:  load_ptr_d = '0;
        StRun:   rot_d      = '0;
        StDrain: rd_ptr_d   = '0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_CLK or posedge i_reset) begin
    if (i_reset) begin
      state_q      <= StIdle;
      load_ptr_q   <= '0;
      rot_q        <= '0;
      rd_ptr_q     <= '0;
      mem_data_q   <= '0;
      mem_we_q     <= '0;
      conv_q       <= '0;
      conv_valid_q <= 1'b0;
      data_q       <= '0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      load_ptr_q   <= load_ptr_d;
      rot_q        <= rot_d;
      rd_ptr_q     <= rd_ptr_d;
      mem_data_q   <= mem_data_d;
      mem_we_q     <= mem_we_d;
      conv_q       <= conv_d;
      conv_valid_q <= conv_valid_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
    end
  end

  assign o_MemData    = mem_data_q;
  assign o_MemWe      = mem_we_q;
  assign o_DataConv   = conv_q;
  assign o_conv_valid = conv_valid_q;
  assign o_Data       = data_q;
  assign o_valid      = valid_q;
  assign o_state      = state_q;

endmodule

// File: tb/tb_mcu_window_router.sv
// Directed bench for mcu_window_router (N=2, four banks of 11-bit lanes).
module tb_mcu_window_router;

  localparam int unsigned N = 2;
  localparam int unsigned W = 11;
  localparam int unsigned M = N + 2;

  logic               clk = 1'b0;
  logic               rst;
  logic [1:0]         cmd;
  logic               cmd_valid;
  logic               in_valid;
  logic [W-1:0]       data_in;
  logic [M*W-1:0]     mem_rd;
  logic [N*W-1:0]     conv_in;
  logic               advance;
  logic               ready;
  logic [M*W-1:0]     mem_wr;
  logic [M-1:0]       mem_we;
  logic [3*N*W-1:0]   conv_out;
  logic               conv_valid;
  logic [W-1:0]       data_out;
  logic               out_valid;
  logic [1:0]         state;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [M*W-1:0]   Banks  = {11'h040, 11'h030, 11'h020, 11'h010};
  localparam logic [N*W-1:0]   ConvIn = {11'h7FF, 11'h111};
  localparam logic [3*N*W-1:0] Win0   = {11'h040, 11'h030, 11'h020, 11'h030, 11'h020, 11'h010};
  localparam logic [3*N*W-1:0] Win2   = {11'h020, 11'h010, 11'h040, 11'h010, 11'h040, 11'h030};
  localparam logic [M*W-1:0]   Wb0    = {11'h000, 11'h000, 11'h7FF, 11'h111};
  localparam logic [M*W-1:0]   Wb2    = {11'h7FF, 11'h111, 11'h000, 11'h000};

  mcu_window_router #(
    .N(N),
    .BITS_IMAGEN(W),
    .BITS_DATA(W)
  ) u_dut (
    .i_CLK       (clk),
    .i_reset     (rst),
    .i_cmd       (cmd),
    .i_cmd_valid (cmd_valid),
    .i_valid     (in_valid),
    .i_Data      (data_in),
    .i_MemData   (mem_rd),
    .i_DataConv  (conv_in),
    .i_advance   (advance),
    .i_ready     (ready),
    .o_MemData   (mem_wr),
    .o_MemWe     (mem_we),
    .o_DataConv  (conv_out),
    .o_conv_valid(conv_valid),
    .o_Data      (data_out),
    .o_valid     (out_valid),
    .o_state     (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, " MemData"}, 128'(mem_wr), 128'(0));
    check({tag, " MemWe"}, 128'(mem_we), 128'(0));
    check({tag, " DataConv"}, 128'(conv_out), 128'(0));
    check({tag, " conv_valid"}, 128'(conv_valid), 128'(0));
    check({tag, " Data"}, 128'(data_out), 128'(0));
    check({tag, " valid"}, 128'(out_valid), 128'(0));
    check({tag, " state"}, 128'(state), 128'(0));
  endtask

  task automatic command(input logic [1:0] c);
    cmd       = c;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
  endtask

  initial begin
    logic [M*W-1:0] exp_wr;
    logic [W-1:0]   drain_exp [4];
    drain_exp = '{11'h020, 11'h030, 11'h040, 11'h010};

    rst = 1'b1; cmd = 2'b00; cmd_valid = 1'b0; in_valid = 1'b0; data_in = '0;
    mem_rd = Banks; conv_in = ConvIn; advance = 1'b0; ready = 1'b0;
    #12;
    check_zero("reset");
    #1 rst = 1'b0;

    // LOAD: six pushes wrap the load pointer after bank 3
    command(2'b01);
    check("load state", 128'(state), 128'(2'b01));
    for (int i = 1; i <= 6; i++) begin
      in_valid = 1'b1;
      data_in  = W'(i);
      step();
      exp_wr = '0;
      exp_wr[((i - 1) % 4) * W +: W] = W'(i);
      check($sformatf("load we %0d", i), 128'(mem_we), 128'(4'b0001 << ((i - 1) % 4)));
      check($sformatf("load data %0d", i), 128'(mem_wr), 128'(exp_wr));
    end
    in_valid = 1'b0;
    step();
    check("load idle we", 128'(mem_we), 128'(0));

    // RUN: window at rot=0, then advance to rot=2 and back
    command(2'b10);
    check("run state", 128'(state), 128'(2'b10));
    in_valid = 1'b1;
    step();
    check("run win0", 128'(conv_out), 128'(Win0));
    check("run cvalid", 128'(conv_valid), 128'(1));
    check("run we0", 128'(mem_we), 128'(4'b0011));
    check("run wb0", 128'(mem_wr), 128'(Wb0));
    advance = 1'b1;
    step();
    check("adv same win", 128'(conv_out), 128'(Win0));
    advance = 1'b0;
    step();
    check("run win2", 128'(conv_out), 128'(Win2));
    check("run we2", 128'(mem_we), 128'(4'b1100));
    check("run wb2", 128'(mem_wr), 128'(Wb2));
    advance = 1'b1;
    step();
    advance = 1'b0;
    step();
    check("rot wrap win0", 128'(conv_out), 128'(Win0));
    check("rot wrap we", 128'(mem_we), 128'(4'b0011));
    in_valid = 1'b0;
    step();
    check("run novalid cv", 128'(conv_valid), 128'(0));
    check("run novalid we", 128'(mem_we), 128'(0));

    // DRAIN with backpressure, then full-rate
    command(2'b11);
    check("drain state", 128'(state), 128'(2'b11));
    check("drain entry valid", 128'(out_valid), 128'(0));
    step();
    check("drain first", 128'(data_out), 128'(11'h010));
    check("drain first v", 128'(out_valid), 128'(1));
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("drain hold %0d", i), 128'(data_out), 128'(11'h010));
      check($sformatf("drain hold v %0d", i), 128'(out_valid), 128'(1));
    end
    ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("drain word %0d", i), 128'(data_out), 128'(drain_exp[i]));
      check($sformatf("drain v %0d", i), 128'(out_valid), 128'(1));
      check($sformatf("drain we %0d", i), 128'(mem_we), 128'(0));
    end
    ready = 1'b0;
    command(2'b00);
    check("leave drain valid", 128'(out_valid), 128'(0));
    check("idle state", 128'(state), 128'(2'b00));

    // Asynchronous reset mid-RUN after rot has moved
    command(2'b10);
    in_valid = 1'b1;
    advance  = 1'b1;
    step();
    advance  = 1'b0;
    check("pre-reset cvalid", 128'(conv_valid), 128'(1));
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    check_zero("midrun reset");
    #2 rst = 1'b0;
    command(2'b10);
    in_valid = 1'b1;
    step();
    check("post-reset win0", 128'(conv_out), 128'(Win0));

    // DRAIN command in the same cycle as a RUN window
    cmd       = 2'b11;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    in_valid  = 1'b0;
    check("cmd+run win", 128'(conv_out), 128'(Win0));
    check("cmd+run cvalid", 128'(conv_valid), 128'(1));
    check("cmd+run we", 128'(mem_we), 128'(4'b0011));
    check("cmd+run state", 128'(state), 128'(2'b11));
    check("cmd+run ovalid", 128'(out_valid), 128'(0));
    ready = 1'b1;
    step();
    check("cmd+run drain0", 128'(data_out), 128'(11'h010));
    check("cmd+run drain0 v", 128'(out_valid), 128'(1));
    step();
    check("cmd+run drain1", 128'(data_out), 128'(11'h020));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mcu_window_router.md
# mcu_window_router

Parametrised memory-control-unit router for the 2D convolution datapath, sitting between the N+2 line-memory banks, the N convolvers and the host data port. It loads pixels round-robin into the banks, feeds each convolver a 3-row window from a rotating bank pointer, writes convolver results back into the freed banks, and drains banks to the output port with valid/ready backpressure. It replaces the fixed N=2, two-substate combinational selector with arbitrary N, a registered datapath and an internal mode FSM.

## Interface
- N, 2, number of convolvers (≥1); bank count M = N+2 is a derived localparam.
- BITS_IMAGEN, 11, pixel/bank lane width.
- BITS_DATA, BITS_IMAGEN, host data width (≤ BITS_IMAGEN).

- i_CLK  in  1  single clock, rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_cmd  in  2  requested mode: 00 IDLE, 01 LOAD, 10 RUN, 11 DRAIN.
- i_cmd_valid  in  1  i_cmd is sampled when high.
- i_valid  in  1  i_Data (LOAD) or i_MemData/i_DataConv (RUN) valid this cycle.
- i_Data  in  BITS_DATA  host pixel.
- i_MemData  in  M*BITS_IMAGEN  bank read data, lane b = bank b.
- i_DataConv  in  N*BITS_IMAGEN  convolver results, lane k = convolver k.
- i_advance  in  1  RUN only: rotate window by N banks.
- i_ready  in  1  downstream accepts o_Data.
- o_MemData  out  M*BITS_IMAGEN  bank write data.
- o_MemWe  out  M  per-bank write enable.
- o_DataConv  out  3*N*BITS_IMAGEN  lane k = 3 pixels for convolver k.
- o_conv_valid  out  1  o_DataConv valid.
- o_Data  out  BITS_DATA  drained pixel.
- o_valid  out  1  o_Data valid.
- o_state  out  2  current FSM state (same encoding as i_cmd).

## Operation
- FSM states IDLE, LOAD, RUN, DRAIN. On i_cmd_valid, next state = i_cmd from any state. Entering LOAD clears load_ptr; entering RUN clears rot; entering DRAIN clears rd_ptr and o_valid. Re-commanding the current state also clears its pointer.
- Same-cycle i_cmd_valid and i_valid: data processed under the current state, new state applies next cycle.
- IDLE: o_MemWe=0, o_conv_valid=0, o_valid=0; pointers hold.
- LOAD: on i_valid, o_MemWe = one-hot(load_ptr), lane load_ptr of o_MemData = i_Data zero-extended to BITS_IMAGEN, other lanes 0; load_ptr ← (load_ptr+1) mod M.
- RUN: on i_valid, for k in 0..N-1, o_DataConv lane k = {bank (rot+k+2)%M, bank (rot+k+1)%M, bank (rot+k)%M} (low slice = oldest row); o_conv_valid=1. Write-back: bank (rot+k)%M ← i_DataConv lane k, o_MemWe bits (rot+k)%M set, others 0. i_advance: rot ← (rot+N) mod M after the current cycle's window; i_advance outside RUN ignored. Without i_valid: o_MemWe=0, o_conv_valid=0.
- DRAIN: when !o_valid or i_ready, o_Data ← low BITS_DATA bits of bank rd_ptr, o_valid=1, rd_ptr ← (rd_ptr+1) mod M. While o_valid && !i_ready, o_Data, o_valid and rd_ptr hold. o_MemWe=0.
- Leaving DRAIN: o_valid cleared next cycle regardless of i_ready.
- All modulo arithmetic on $clog2(M)-bit pointers with explicit wrap at M (M need not be a power of 2).

## Timing
- All outputs registered; one-cycle latency from sampled inputs to o_MemData/o_MemWe/o_DataConv/o_conv_valid/o_Data.
- i_MemData is treated as combinational bank read for the current pointers.
- Reset (asynchronous, any cycle, mid-operation included): state IDLE, load_ptr=rot=rd_ptr=0, o_MemData=0, o_MemWe=0, o_DataConv=0, o_conv_valid=0, o_Data=0, o_valid=0, o_state=00. First post-reset edge acts on inputs normally.
- Drain throughput one word/cycle with i_ready held high.

## Test plan
- Reset then LOAD (N=2, M=4), push 0x001..0x006 → o_MemWe 0001,0010,0100,1000,0001,0010; lane 0 data 0x005 on 5th write; load_ptr wraps at 4.
- RUN, banks = {b3..b0}=0x40,0x30,0x20,0x10, rot=0, i_valid → lane0={0x30,0x20,0x10}, lane1={0x40,0x30,0x20}; i_DataConv {0x7FF,0x111} → o_MemWe=0011.
- i_advance with i_valid → next window rot=2: lane0={0x10,0x40,0x30}, lane1={0x20,0x10,0x40}, o_MemWe=1100; second advance returns rot=0.
- DRAIN with i_ready low 3 cycles after first word → o_Data=0x10 held, o_valid=1; i_ready high → 0x20,0x30,0x40,0x10 on consecutive cycles.
- Assert i_reset mid-RUN with o_conv_valid=1 → all outputs 0 immediately, o_state=00; next RUN starts at rot=0.
- i_cmd_valid (DRAIN) same cycle as RUN i_valid → that window still emitted with write-back, o_state=11 next cycle, first drained word is bank 0.
